// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and sizing helpers for the seven-segment display driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Active-low glyphs, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Bits needed for a counter that must hold max_val
  function automatic int cnt_width(input longint unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

  // 10^n, used for the decimal overflow bound
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational 4-bit to active-low seven-segment decoder (gfedcba), with blank override.
module seg7_hex
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup; lower-case b and d keep 0xB/0xD distinct from 8/0
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Multi-digit score display driver: sequential double-dabble binary-to-BCD (or hex
// pass-through), one-deep pending load slot, leading-zero blanking, overflow dashes, blink.
module score_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VALUE_W    = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*7-1:0] leds
);

  localparam int          DW      = 4 * NUM_DIGITS;
  localparam int          BW      = cnt_width(longint'(VALUE_W));
  localparam int          KW      = cnt_width(longint'(BLINK_DIV - 1));
  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the next value bit
  function automatic logic [DW-1:0] dabble_step(input logic [DW-1:0] b, input logic bit_in);
    logic [DW-1:0] a;
    a = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[DW-2:0], bit_in};
  endfunction

  // Value cannot be represented on the available digits
  function automatic logic is_ovf(input logic [VALUE_W-1:0] v, input logic hx);
    logic [63:0] v64;
    v64 = 64'(v);
    if (hx) return (v64 >> DW) != 64'd0;
    return v64 > DEC_MAX;
  endfunction

  // Hex nibbles straight from the value, zero-extended or truncated to the digit count
  function automatic logic [DW-1:0] hex_digits(input logic [VALUE_W-1:0] v);
    return DW'(v);
  endfunction

  // Blank every digit above the most significant nonzero one; digit 0 always shown
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] d, input logic blz);
    logic [NUM_DIGITS-1:0] m;
    logic                  hi_zero;
    m       = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (d[i*4 +: 4] != 4'd0) hi_zero = 1'b0;
      m[i] = blz & hi_zero;
    end
    return m;
  endfunction

  state_t                  state, state_nx;

  logic [VALUE_W-1:0]      val_sh;
  logic [DW-1:0]           bcd;
  logic [BW-1:0]           bit_cnt;
  logic                    cur_hex, cur_blz, cur_ovf;

  logic                    pend_vld;
  logic [VALUE_W-1:0]      pend_val;
  logic                    pend_hex, pend_blz;

  logic [DW-1:0]           digits;
  logic [NUM_DIGITS-1:0]   mask;
  logic                    ovf_q;

  logic [KW-1:0]           blink_cnt;
  logic                    phase;

  logic                    start_go, take_pend, store_pend;
  logic [VALUE_W-1:0]      src_val;
  logic                    src_hex, src_blz;
  logic [DW-1:0]           latch_digits;

  assign latch_digits = cur_hex ? hex_digits(val_sh) : bcd;

  // Next state plus selection of which request (live or pending) starts next
  always_comb begin
    state_nx   = state;
    start_go   = 1'b0;
    take_pend  = 1'b0;
    store_pend = 1'b0;
    src_val    = value;
    src_hex    = hex_mode;
    src_blz    = blank_lz;
    case (state)
      IDLE: begin
        if (load) begin
          start_go = 1'b1;
          state_nx = hex_mode ? LATCH : SHIFT;
        end
      end
      SHIFT: begin
        store_pend = load;
        if (bit_cnt == BW'(1)) state_nx = LATCH;
      end
      LATCH: begin
        if (pend_vld) begin
          take_pend  = 1'b1;
          start_go   = 1'b1;
          src_val    = pend_val;
          src_hex    = pend_hex;
          src_blz    = pend_blz;
          store_pend = load;
        end else if (load) begin
          start_go = 1'b1;
        end
        state_nx = start_go ? (src_hex ? LATCH : SHIFT) : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Control: busy/done flags, pending-slot valid, displayed blank mask and overflow flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pend_vld <= 1'b0;
      mask     <= '1;
      ovf_q    <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state == LATCH);
      if (store_pend)     pend_vld <= 1'b1;
      else if (take_pend) pend_vld <= 1'b0;
      if (state == LATCH) begin
        ovf_q <= cur_ovf;
        mask  <= cur_ovf ? '0 : lz_mask(latch_digits, cur_blz);
      end
    end
  end

  // Datapath: pending slot contents, conversion registers and digit register
  always_ff @(posedge clk) begin
    if (store_pend) begin
      pend_val <= value;
      pend_hex <= hex_mode;
      pend_blz <= blank_lz;
    end
    if (start_go) begin
      val_sh  <= src_val;
      cur_hex <= src_hex;
      cur_blz <= src_blz;
      cur_ovf <= is_ovf(src_val, src_hex);
      bcd     <= '0;
      bit_cnt <= BW'(VALUE_W);
    end else if (state == SHIFT) begin
      bcd     <= dabble_step(bcd, val_sh[VALUE_W-1]);
      val_sh  <= val_sh << 1;
      bit_cnt <= bit_cnt - BW'(1);
    end
    if (state == LATCH) digits <= latch_digits;
  end

  // Free-running blink divider; phase toggles once per half-period
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == KW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + KW'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [6:0] glyph;
    seg7_hex u_hex (
      .digit (digits[g*4 +: 4]),
      .blank (mask[g]),
      .seg   (glyph)
    );
    assign leds[g*7 +: 7] = (blink_en && phase) ? SEG_BLANK :
                            ovf_q               ? SEG_DASH  : glyph;
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: scoreboard of expected leds pushed at load,
// popped and compared on each done pulse.
module tb_score_display;

  localparam int ND = 6;
  localparam int VW = 20;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            reset_n, load, hex_mode, blank_lz, blink_en;
  logic [VW-1:0]   value;
  logic            busy, done;
  logic [ND*7-1:0] leds;

  int errors = 0;
  int checks = 0;

  logic [ND*7-1:0] exp_q[$];

  int bcnt;
  bit bph;

  score_display #(
    .NUM_DIGITS (ND),
    .VALUE_W    (VW),
    .BLINK_DIV  (BD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .busy     (busy),
    .done     (done),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  // Reference blink phase
  always @(posedge clk) begin
    if (!reset_n) begin
      bcnt <= 0;
      bph  <= 1'b0;
    end else if (bcnt == BD - 1) begin
      bcnt <= 0;
      bph  <= ~bph;
    end else begin
      bcnt <= bcnt + 1;
    end
  end

  function automatic logic [6:0] seg(input int unsigned d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // Reference display image computed with division/modulo
  function automatic logic [ND*7-1:0] model(input int unsigned v, input bit hx, input bit blz);
    int unsigned dg[ND];
    int unsigned p;
    int          msd;
    bit          ovf;
    logic [ND*7-1:0] r;
    p   = 1;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      dg[i] = hx ? ((v >> (4 * i)) & 32'd15) : ((v / p) % 10);
      p     = p * 10;
    end
    ovf = hx ? ((v >> (4 * ND)) != 0) : (v > p - 1);
    for (int i = 0; i < ND; i++) if (dg[i] != 0) msd = i;
    for (int i = 0; i < ND; i++) begin
      if (ovf)                 r[i*7 +: 7] = 7'b0111111;
      else if (blz && i > msd) r[i*7 +: 7] = 7'b1111111;
      else                     r[i*7 +: 7] = seg(dg[i]);
    end
    return r;
  endfunction

  task automatic do_load(input int unsigned v, input bit hx, input bit blz, input bit push);
    @(negedge clk);
    value    = v[VW-1:0];
    hex_mode = hx;
    blank_lz = blz;
    load     = 1'b1;
    if (push) exp_q.push_back(model(v, hx, blz));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0; blink_en = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (leds !== {ND*7{1'b1}}) begin errors++; $display("FAIL reset_leds got=%b exp=all ones", leds); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (leds !== {ND*7{1'b1}} || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle leds=%b busy=%b exp=all ones/0", leds, busy);
    end
  endtask

  task automatic test_decimal;
    int n; bit ok; logic [ND*7-1:0] e;
    do_load(1234, 1'b0, 1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy got=%b exp=1", busy); end
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dec_timeout got=no done exp=done"); end
    checks++; if (n != VW + 1) begin errors++; $display("FAIL dec_latency got=%0d exp=%0d", n, VW + 1); end
    e = exp_q.pop_front();
    checks++; if (leds !== e) begin errors++; $display("FAIL dec_1234 got=%b exp=%b", leds, e); end
    checks++; if (leds[6:0] !== 7'b0011001 || leds[27:21] !== 7'b1111001) begin
      errors++; $display("FAIL dec_1234_digits got=%b/%b exp=0011001/1111001", leds[6:0], leds[27:21]);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dec_done_pulse got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_hex;
    int n; bit ok; logic [ND*7-1:0] e;
    do_load(32'hBEEF, 1'b1, 1'b0, 1'b1);
    wait_done(n, ok);
    checks++; if (!ok || n != 1) begin errors++; $display("FAIL hex_latency got=%0d ok=%0d exp=1", n, ok); end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    checks++; if (leds !== e) begin errors++; $display("FAIL hex_beef got=%b exp=%b", leds, e); end
    checks++; if (leds[6:0] !== 7'b0001110 || leds[41:35] !== 7'b1000000) begin
      errors++; $display("FAIL hex_beef_digits got=%b/%b exp=0001110/1000000", leds[6:0], leds[41:35]);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hex_end got done=%b busy=%b exp=0/0", done, busy);
    end
  endtask

  task automatic test_boundaries;
    int unsigned vals[6] = '{1000000, 0, 999999, 1048575, 32'h00A0D, 90817};
    bit          hxs[6]  = '{0, 0, 0, 0, 1, 0};
    bit          blzs[6] = '{1, 1, 0, 1, 1, 0};
    int n; bit ok; logic [ND*7-1:0] e;
    for (int k = 0; k < 6; k++) begin
      do_load(vals[k], hxs[k], blzs[k], 1'b1);
      wait_done(n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bound_timeout case=%0d got=no done exp=done", k); end
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
      checks++; if (leds !== e) begin errors++; $display("FAIL bound_leds case=%0d got=%b exp=%b", k, leds, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit ok; bit extra; logic [ND*7-1:0] e;
    do_load(42, 1'b0, 1'b1, 1'b1);
    do_load(7, 1'b0, 1'b1, 1'b0);
    do_load(99, 1'b0, 1'b1, 1'b1);
    wait_done(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got=no done exp=done"); end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    checks++; if (leds !== e) begin errors++; $display("FAIL b2b_42 got=%b exp=%b", leds, e); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_cont got=%b exp=1", busy); end
    wait_done(n, ok);
    checks++; if (!ok || n + 1 != VW + 1) begin
      errors++; $display("FAIL b2b_gap got=%0d exp=%0d", n + 1, VW + 1);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    checks++; if (leds !== e) begin errors++; $display("FAIL b2b_99 got=%b exp=%b", leds, e); end
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra = 1'b1;
    end
    checks++; if (extra || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_no_third got extra=%b busy=%b exp=0/0", extra, busy);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int n; bit ok; logic [ND*7-1:0] e;
    do_load(123456, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (leds !== {ND*7{1'b1}}) begin errors++; $display("FAIL mid_reset_leds got=%b exp=all ones", leds); end
    reset_n = 1'b1;
    do_load(654321, 1'b0, 1'b0, 1'b1);
    wait_done(n, ok);
    checks++; if (!ok || n != VW + 1) begin errors++; $display("FAIL mid_fresh_latency got=%0d exp=%0d", n, VW + 1); end
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    checks++; if (leds !== e) begin errors++; $display("FAIL mid_fresh got=%b exp=%b", leds, e); end
    @(negedge clk);
  endtask

  task automatic test_blink;
    int n; bit ok; bit saw_on; bit saw_off; logic [ND*7-1:0] e; logic [6:0] x;
    do_load(5, 1'b0, 1'b1, 1'b1);
    wait_done(n, ok);
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    checks++; if (!ok || leds !== e) begin errors++; $display("FAIL blink_setup got=%b exp=%b", leds, e); end
    blink_en = 1'b1;
    saw_on = 1'b0; saw_off = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      x = bph ? 7'b1111111 : 7'b0010010;
      if (bph) saw_off = 1'b1; else saw_on = 1'b1;
      checks++; if (leds[6:0] !== x || leds[41:7] !== {35{1'b1}}) begin
        errors++; $display("FAIL blink_cycle%0d got=%b exp=%b", c, leds[6:0], x);
      end
    end
    checks++; if (!(saw_on && saw_off)) begin errors++; $display("FAIL blink_phases got on=%b off=%b exp=1/1", saw_on, saw_off); end
    blink_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (leds[6:0] !== 7'b0010010) begin
        errors++; $display("FAIL blink_off_cycle%0d got=%b exp=0010010", c, leds[6:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Parametrised multi-digit seven-segment display driver for the game's score and status readouts. It accepts a binary value on a load strobe, converts it to BCD with a sequential double-dabble engine, or passes it straight through as hex nibbles in hex mode. The registered digits drive NUM_DIGITS active-low seven-segment outputs, with leading-zero blanking, overflow dashes and optional blink. It sits between the game-state logic and the board HEX displays and replaces the per-digit combinational decoders.

## Interface
- NUM_DIGITS, 6, number of displayed digits (1..8)
- VALUE_W, 20, width of the binary input value (≥4)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2)

Ports:
- clk  input  1  system clock; single clock domain
- reset_n  input  1  synchronous, active-low reset
- value  input  VALUE_W  binary value to display; sampled only on an accepted load
- load  input  1  one-cycle strobe requesting a display update
- hex_mode  input  1  1 = show value as hex nibbles, 0 = decimal; sampled with value
- blank_lz  input  1  1 = blank leading zero digits; sampled with value
- blink_en  input  1  1 = blink the whole display; applied live, not sampled
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when new digits are latched
- leds  output  NUM_DIGITS×7  leds[i] = digit i (0 = least significant), bit order gfedcba, active-low

## Operation
- FSM states: IDLE, SHIFT, LATCH.
- IDLE with load=1: capture value, hex_mode and blank_lz.
  - Decimal: go to SHIFT with bit counter = VALUE_W and BCD accumulator cleared.
  - Hex: go to LATCH directly.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, bringing in the value's MSB. Decrement the counter and go to LATCH when it reaches 0 after the last shift.
- LATCH:
  - Write the digit register and the blank mask.
  - Pulse done.
  - If a pending load exists, start it: SHIFT for decimal, or stay in LATCH for hex. Otherwise go to IDLE.
- Load while not IDLE: store value, hex_mode and blank_lz in a one-deep pending slot. A newer load overwrites the older one. The pending load is never lost and is never merged into the conversion in flight.
- Overflow:
  - Decimal: value > 10^NUM_DIGITS − 1.
  - Hex: any value bit at index ≥ 4·NUM_DIGITS is set.
  - Detected at capture. All digits then show a dash (segment g only, 7'b0111111) and blanking is ignored.
- Leading-zero blanking: digits above the most significant nonzero digit show blank (7'b1111111). Digit 0 is never blanked, so value 0 shows "0".
- Digits decode 0–9 and A–F. Lower-case b and d are used for 0xB and 0xD.
- Blink: a free-running counter wraps at BLINK_DIV−1 and toggles the phase bit on wrap. While blink_en=1 and phase=1, all leds are blank. Conversion is unaffected.

## Timing
- Reset (reset_n=0 at a clk edge):
  - State IDLE; pending slot cleared.
  - busy=0, done=0.
  - Digit register shows blank on all digits (leds all 7'b1111111).
  - Blink counter and phase cleared to 0.
- Reset mid-conversion aborts the conversion. Old digits are cleared to blank, not retained.
- busy is registered. It is 1 from the edge that accepts a load until the edge that leaves LATCH to IDLE.
- Decimal latency: a load accepted at edge E0 shows new leds after edge E0+VALUE_W+1. done is high in the cycle that follows.
- Hex latency: leds update after edge E0+1. done is high in the cycle that follows.
- leds are combinational from the digit register, blank mask and blink phase. There is no additional register stage.
- Pending load at LATCH: the next conversion starts at the same edge as done, with no idle cycle between them.
- load and reset_n both asserted at the same edge: reset wins.

## Structure
- seg7_pkg holds:
  - state enum (IDLE, SHIFT, LATCH)
  - glyph constants SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111
  - function clog2-based counter width
- Sub-module seg7_hex: combinational 4-bit → 7-bit active-low decoder for all 16 codes plus a blank input. It is instantiated NUM_DIGITS times.
- Double-dabble datapath, pending slot, FSM and blink counter live in score_display.

## Test plan
- Reset, then decimal load value=1234 with blank_lz=1 and NUM_DIGITS=6:
  - after VALUE_W+1 edges: leds[0..3] = 0011001, 0110000, 0100100, 1111001; leds[4..5] = 1111111
  - done pulses once
- hex_mode=1, value=0xBEEF, blank_lz=0:
  - one edge later: leds[0..3] = 0001110, 0000110, 0000110, 0000011; leds[4..5] = 1000000
- Decimal value=1_000_000 (NUM_DIGITS=6) → all six leds = 0111111. value=0 with blank_lz=1 → leds[0]=1000000, rest 1111111.
- Load 42, then load 7 while busy, then load 99 while still busy:
  - 42 displays first
  - 99 then displays with back-to-back conversion
  - 7 never appears
  - two done pulses total
- reset_n=0 on the 5th SHIFT cycle → next cycle busy=0 and leds all 1111111. A fresh load converts correctly.
- BLINK_DIV=4, blink_en=1, display showing 5 → leds[0] alternates 0010010 / 1111111 every 4 cycles. blink_en=0 → steady 0010010.
